pattern_sequencer: RTL and testbench

Top-level scheduler for the VGA pattern generators. It decides which generator is live, raises exactly one `pattern_enable` at a time, inserts a blanked transition of a fixed number of frames between patterns, and muxes the selected generator's 6-bit RGB onto the display output. Advance is automatic after a dwell period, or manual from a push-button. It sits between the sync/timing generator (`next_frame`, `active`) and the pattern generators; it does not generate or modify step sizes.

---
 rtl/pattern_pkg.sv | 13 +
 rtl/btn_sync_edge.sv | 28 ++
 rtl/pattern_sequencer.sv | 139 +++++++++++++
 tb/tb_pattern_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and widths for the VGA pattern scheduler and its helpers.
package pattern_pkg;

  localparam int unsigned RGB_W        = 6;
  localparam int unsigned MAX_PATTERNS = 8;
  localparam int unsigned IDX_W        = 3;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous push-button followed by a
// single-cycle rising-edge detector.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign edge_pulse = sync2 & ~sync2_d;

endmodule

// File: rtl/pattern_sequencer.sv
// Schedules which pattern generator is live, blanks between patterns and
// muxes the live generator's colour onto the display output.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 4,
  parameter int unsigned DWELL_FRAMES = 240,
  parameter int unsigned BLANK_FRAMES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          next_frame,
  input  logic                          active,
  input  logic                          btn_next,
  input  logic                          btn_mode,
  input  logic [RGB_W*NUM_PATTERNS-1:0] rgb_in,
  output logic [NUM_PATTERNS-1:0]       pattern_enable,
  output logic [RGB_W-1:0]              rgb_out,
  output logic [IDX_W-1:0]              pattern_idx,
  output logic                          auto_mode
);

  localparam int unsigned DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int unsigned BW_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
  localparam logic [BW_W-1:0]  BLANK_LAST = BW_W'(BLANK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_PATTERNS - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [IDX_W-1:0]          idx_nxt;
  logic [DW_W-1:0]           dwell_cnt;
  logic [DW_W-1:0]           dwell_nxt;
  logic [BW_W-1:0]           blank_cnt;
  logic [BW_W-1:0]           blank_nxt;
  logic                      auto_nxt;
  logic [NUM_PATTERNS-1:0]   enable_nxt;
  logic [RGB_W-1:0]          rgb_sel;
  logic [RGB_W-1:0]          rgb_nxt;
  logic                      next_edge;
  logic                      mode_edge;
  logic                      dwell_done;

  btn_sync_edge u_next_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (btn_next),
    .edge_pulse (next_edge)
  );

  btn_sync_edge u_mode_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (btn_mode),
    .edge_pulse (mode_edge)
  );

  // Select the live generator's colour slot.
  always_comb begin
    rgb_sel = '0;
    for (int i = 0; i < int'(NUM_PATTERNS); i++) begin
      if (pattern_idx == IDX_W'(i)) begin
        rgb_sel = rgb_in[i*RGB_W +: RGB_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_SHOW;
      pattern_idx    <= '0;
      dwell_cnt      <= '0;
      blank_cnt      <= '0;
      auto_mode      <= 1'b1;
      pattern_enable <= NUM_PATTERNS'(1);
      rgb_out        <= '0;
    end else begin
      state          <= state_nxt;
      pattern_idx    <= idx_nxt;
      dwell_cnt      <= dwell_nxt;
      blank_cnt      <= blank_nxt;
      auto_mode      <= auto_nxt;
      pattern_enable <= enable_nxt;
      rgb_out        <= rgb_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = pattern_idx;
    dwell_nxt  = dwell_cnt;
    blank_nxt  = blank_cnt;
    auto_nxt   = auto_mode;
    dwell_done = 1'b0;

    if (mode_edge) begin
      auto_nxt = ~auto_mode;
    end

    case (state)
      ST_SHOW: begin
        dwell_done = auto_mode && next_frame && (dwell_cnt == DWELL_LAST);
        if (!auto_mode) begin
          dwell_nxt = '0;
        end else if (next_frame) begin
          dwell_nxt = dwell_cnt + DW_W'(1);
        end
        // A button edge coinciding with dwell expiry still yields one step.
        if (next_edge || dwell_done) begin
          state_nxt = ST_BLANK;
          idx_nxt   = (pattern_idx == IDX_LAST) ? '0 : pattern_idx + IDX_W'(1);
          dwell_nxt = '0;
          blank_nxt = '0;
        end
      end
      ST_BLANK: begin
        if (next_frame) begin
          if (blank_cnt == BLANK_LAST) begin
            state_nxt = ST_SHOW;
            blank_nxt = '0;
          end else begin
            blank_nxt = blank_cnt + BW_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_SHOW;
      end
    endcase

    if (mode_edge) begin
      dwell_nxt = '0;
    end

    enable_nxt = (state_nxt == ST_SHOW) ? (NUM_PATTERNS'(1) << idx_nxt) : '0;
    rgb_nxt    = ((state == ST_SHOW) && active) ? rgb_sel : '0;
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: directed scenarios plus random
// stimulus scored against a frame-counting behavioural model.
module tb_pattern_sequencer;

  localparam int NP = 3;
  localparam int DW = 4;
  localparam int BF = 2;

  logic            clk;
  logic            rst;
  logic            next_frame;
  logic            active;
  logic            btn_next;
  logic            btn_mode;
  logic [6*NP-1:0] rgb_in;
  logic [NP-1:0]   pattern_enable;
  logic [5:0]      rgb_out;
  logic [2:0]      pattern_idx;
  logic            auto_mode;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase flag, pattern index, pulses seen in this phase.
  bit       m_show;
  int       m_idx;
  int       m_frames;
  bit       m_auto;
  logic [5:0] m_rgb;
  bit       hn1, hn2, hn3;
  bit       hm1, hm2, hm3;

  pattern_sequencer #(
    .NUM_PATTERNS (NP),
    .DWELL_FRAMES (DW),
    .BLANK_FRAMES (BF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .next_frame     (next_frame),
    .active         (active),
    .btn_next       (btn_next),
    .btn_mode       (btn_mode),
    .rgb_in         (rgb_in),
    .pattern_enable (pattern_enable),
    .rgb_out        (rgb_out),
    .pattern_idx    (pattern_idx),
    .auto_mode      (auto_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NP-1:0] exp_en();
    logic [NP-1:0] v;
    v = '0;
    if (m_show) v[m_idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_show = 1; m_idx = 0; m_frames = 0; m_auto = 1; m_rgb = '0;
    hn1 = 0; hn2 = 0; hn3 = 0; hm1 = 0; hm2 = 0; hm3 = 0;
  endtask

  // One clock edge of the model; a button level seen at edge k acts at edge k+2.
  task automatic model_edge();
    bit   bn_ev, bm_ev, old_auto, expire;
    logic [5:0] slot;
    bn_ev = hn2 && !hn3;
    bm_ev = hm2 && !hm3;
    hn3 = hn2; hn2 = hn1; hn1 = btn_next;
    hm3 = hm2; hm2 = hm1; hm1 = btn_mode;
    slot  = rgb_in[6*m_idx +: 6];
    m_rgb = (m_show && active) ? slot : 6'h00;
    old_auto = m_auto;
    if (bm_ev) m_auto = !m_auto;
    if (m_show) begin
      if (old_auto && next_frame) m_frames++;
      expire = old_auto && next_frame && (m_frames == DW);
      if (!old_auto || bm_ev) m_frames = 0;
      if (bn_ev || expire) begin
        m_show = 0;
        m_idx = (m_idx + 1) % NP;
        m_frames = 0;
      end
    end else begin
      if (next_frame) m_frames++;
      if (m_frames == BF) begin
        m_show = 1;
        m_frames = 0;
      end
    end
  endtask

  task automatic tick(input logic f, input logic a, input logic b, input logic m);
    next_frame = f; active = a; btn_next = b; btn_mode = m;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    next_frame = 0; active = 0; btn_next = 0; btn_mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (pattern_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", pattern_idx); end
    total++; if (pattern_enable !== 3'b001) begin bad++; $display("FAIL reset_en: got %b want 001", pattern_enable); end
    total++; if (auto_mode !== 1'b1) begin bad++; $display("FAIL reset_auto: got %b want 1", auto_mode); end
    total++; if (rgb_out !== 6'h00) begin bad++; $display("FAIL reset_rgb: got %h want 00", rgb_out); end
    apply_reset();
  endtask

  task automatic test_auto_advance();
    apply_reset();
    pulses(3);
    tick(1, 0, 0, 0);
    total++; if (pattern_enable !== 3'b000) begin bad++; $display("FAIL adv_blank_en: got %b want 000", pattern_enable); end
    total++; if (pattern_idx !== 3'd1) begin bad++; $display("FAIL adv_idx: got %0d want 1", pattern_idx); end
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    total++; if (pattern_enable !== 3'b000) begin bad++; $display("FAIL adv_blank_mid: got %b want 000", pattern_enable); end
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    total++; if (pattern_enable !== 3'b010) begin bad++; $display("FAIL adv_show_en: got %b want 010", pattern_enable); end
  endtask

  task automatic test_auto_cycles();
    int seq[$];
    logic [NP-1:0] prev;
    apply_reset();
    seq.push_back(int'(pattern_idx));
    prev = pattern_enable;
    for (int i = 0; i < 36; i++) begin
      tick(i % 2 == 0, 0, 0, 0);
      total++; if ($countones(pattern_enable) > 1 || pattern_enable !== exp_en()) begin
        bad++; $display("FAIL cyc_en: got %b want %b", pattern_enable, exp_en());
      end
      if (prev == '0 && pattern_enable != '0) seq.push_back(int'(pattern_idx));
      prev = pattern_enable;
    end
    total++; if (seq.size() != 4) begin bad++; $display("FAIL cyc_count: got %0d want 4", seq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (seq[i] != (i % NP)) begin bad++; $display("FAIL cyc_seq%0d: got %0d want %0d", i, seq[i], i % NP); end
      end
    end
  endtask

  task automatic test_btn_next();
    apply_reset();
    pulses(1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    total++; if (pattern_enable !== 3'b001 || pattern_idx !== 3'd0) begin
      bad++; $display("FAIL btn_k1: got en=%b idx=%0d want en=001 idx=0", pattern_enable, pattern_idx);
    end
    tick(0, 0, 1, 0);
    total++; if (pattern_enable !== 3'b000 || pattern_idx !== 3'd1) begin
      bad++; $display("FAIL btn_k2: got en=%b idx=%0d want en=000 idx=1", pattern_enable, pattern_idx);
    end
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    repeat (4) tick(0, 0, 1, 0);
    repeat (3) tick(0, 0, 0, 0);
    total++; if (pattern_enable !== 3'b000 || pattern_idx !== 3'd1) begin
      bad++; $display("FAIL btn_blank_drop: got en=%b idx=%0d want en=000 idx=1", pattern_enable, pattern_idx);
    end
    pulses(2);
    total++; if (pattern_enable !== 3'b010) begin bad++; $display("FAIL btn_show: got %b want 010", pattern_enable); end
    pulses(3);
    total++; if (pattern_enable !== 3'b010) begin bad++; $display("FAIL btn_dwell_fresh: got %b want 010", pattern_enable); end
    pulses(1);
    total++; if (pattern_enable !== 3'b000 || pattern_idx !== 3'd2) begin
      bad++; $display("FAIL btn_dwell_end: got en=%b idx=%0d want en=000 idx=2", pattern_enable, pattern_idx);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    pulses(3);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(1, 0, 1, 0);
    total++; if (pattern_idx !== 3'd1 || pattern_enable !== 3'b000) begin
      bad++; $display("FAIL sim_adv: got idx=%0d en=%b want idx=1 en=000", pattern_idx, pattern_enable);
    end
    repeat (4) tick(0, 0, 0, 0);
    pulses(2);
    total++; if (pattern_idx !== 3'd1 || pattern_enable !== 3'b010) begin
      bad++; $display("FAIL sim_once: got idx=%0d en=%b want idx=1 en=010", pattern_idx, pattern_enable);
    end
  endtask

  task automatic test_mode();
    apply_reset();
    pulses(2);
    repeat (3) tick(0, 0, 0, 1);
    total++; if (auto_mode !== 1'b0) begin bad++; $display("FAIL mode_manual: got %b want 0", auto_mode); end
    tick(0, 0, 0, 0);
    pulses(10);
    total++; if (pattern_idx !== 3'd0 || pattern_enable !== 3'b001) begin
      bad++; $display("FAIL mode_hold: got idx=%0d en=%b want idx=0 en=001", pattern_idx, pattern_enable);
    end
    repeat (3) tick(0, 0, 0, 1);
    total++; if (auto_mode !== 1'b1) begin bad++; $display("FAIL mode_auto: got %b want 1", auto_mode); end
    tick(0, 0, 0, 0);
    pulses(3);
    total++; if (pattern_enable !== 3'b001) begin bad++; $display("FAIL mode_restart: got %b want 001", pattern_enable); end
    pulses(1);
    total++; if (pattern_idx !== 3'd1 || pattern_enable !== 3'b000) begin
      bad++; $display("FAIL mode_adv: got idx=%0d en=%b want idx=1 en=000", pattern_idx, pattern_enable);
    end
  endtask

  task automatic test_rgb();
    apply_reset();
    rgb_in = {6'h03, 6'h0C, 6'h30};
    pulses(6);
    tick(0, 1, 0, 0);
    total++; if (rgb_out !== 6'h0C) begin bad++; $display("FAIL rgb_show: got %h want 0c", rgb_out); end
    tick(0, 0, 0, 0);
    total++; if (rgb_out !== 6'h00) begin bad++; $display("FAIL rgb_inactive: got %h want 00", rgb_out); end
    pulses(4);
    tick(0, 1, 0, 0);
    total++; if (rgb_out !== 6'h00) begin bad++; $display("FAIL rgb_blank: got %h want 00", rgb_out); end
  endtask

  task automatic test_reset_mid_blank();
    apply_reset();
    repeat (3) tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    repeat (3) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    pulses(1);
    total++; if (pattern_enable !== 3'b000 || auto_mode !== 1'b0 || pattern_idx !== 3'd1) begin
      bad++; $display("FAIL rstb_pre: got en=%b auto=%b idx=%0d want en=000 auto=0 idx=1", pattern_enable, auto_mode, pattern_idx);
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (pattern_enable !== 3'b001 || auto_mode !== 1'b1 || pattern_idx !== 3'd0 || rgb_out !== 6'h00) begin
      bad++; $display("FAIL rstb_async: got en=%b auto=%b idx=%0d rgb=%h want en=001 auto=1 idx=0 rgb=00",
                      pattern_enable, auto_mode, pattern_idx, rgb_out);
    end
    apply_reset();
  endtask

  task automatic test_random();
    logic bnl, bml;
    apply_reset();
    bnl = 0; bml = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) bnl = ~bnl;
      if ($urandom_range(40) == 0) bml = ~bml;
      rgb_in = (6*NP)'($urandom);
      tick($urandom_range(2) == 0, 1'($urandom_range(1)), bnl, bml);
      total++; if (pattern_idx !== 3'(m_idx)) begin bad++; $display("FAIL rnd_idx@%0d: got %0d want %0d", i, pattern_idx, m_idx); end
      total++; if (pattern_enable !== exp_en()) begin bad++; $display("FAIL rnd_en@%0d: got %b want %b", i, pattern_enable, exp_en()); end
      total++; if (auto_mode !== m_auto) begin bad++; $display("FAIL rnd_auto@%0d: got %b want %b", i, auto_mode, m_auto); end
      total++; if (rgb_out !== m_rgb) begin bad++; $display("FAIL rnd_rgb@%0d: got %h want %h", i, rgb_out, m_rgb); end
    end
  endtask

  initial begin
    rst = 1'b1;
    next_frame = 0; active = 0; btn_next = 0; btn_mode = 0;
    rgb_in = '0;
    model_reset();
    test_reset();
    test_auto_advance();
    test_auto_cycles();
    test_btn_next();
    test_simultaneous();
    test_mode();
    test_rgb();
    test_reset_mid_blank();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
